datapath_sequencer: RTL

Multi-cycle controller that sequences the processor datapath (register file `rf`, data memory `dm`, adder/subtractor `adder_sub`) for one instruction at a time. It accepts an instruction on a start/done handshake and walks a fixed state machine that:
- loads operands from data memory into the register file,
- computes through the adder/subtractor,
- writes the result back to data memory.

It drives every control and data input of the three instances and sits between the instruction source (testbench or future fetch/decode) and the datapath.

---
 rtl/datapath_sequencer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle controller that runs one instruction at a
// time through the register file, data memory and adder/subtractor.
//
// Optional feature macro: SEQ_READBACK_EN
//   defined   -> after the data-memory write, the written word is read back
//                and compared with the result; a mismatch raises error.
//   undefined -> DM_WR goes straight to DONE; error only flags bad op_codes.
//
// Handshake: start/op_code/rs1/rs2/rd are sampled only on a rising edge while
// the FSM is in IDLE (busy=0). That edge is the accept. The operands are held
// internally until the next accept. start seen in any other state is dropped,
// not queued. Completion is a one-cycle done pulse. error and result are
// valid while done is high, and result stays valid until the next accept.

module datapath_sequencer #(
  parameter int WORDSIZE = 64,
  parameter int ADDRW    = 5
) (
  input  logic                clk,
  input  logic                rst,

  // instruction side
  input  logic                start,
  input  logic [6:0]          op_code,
  input  logic [ADDRW-1:0]    rs1,
  input  logic [ADDRW-1:0]    rs2,
  input  logic [ADDRW-1:0]    rd,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [WORDSIZE-1:0] result,

  // register file
  output logic                rf_write_en,
  output logic [ADDRW-1:0]    rf_write_addr,
  output logic [WORDSIZE-1:0] rf_write_data,
  output logic [ADDRW-1:0]    rf_addr_a,
  output logic [ADDRW-1:0]    rf_addr_b,
  input  logic [WORDSIZE-1:0] rf_data_a,
  input  logic [WORDSIZE-1:0] rf_data_b,

  // data memory
  output logic [ADDRW-1:0]    dm_addr,
  output logic [WORDSIZE-1:0] dm_data_input,
  output logic                dm_write_enable,
  output logic                dm_read,
  input  logic [WORDSIZE-1:0] dm_data_output,

  // adder / subtractor
  output logic [WORDSIZE-1:0] adder_sub_factor_a,
  output logic [WORDSIZE-1:0] adder_sub_factor_b,
  output logic                adder_sub_operation,
  input  logic [WORDSIZE-1:0] adder_sub_result,

  // current FSM state, for observation only
  output logic [3:0]          state_dbg
);

  localparam logic [6:0] OP_NONE  = 7'h00;
  localparam logic [6:0] OP_STORE = 7'h01;
  localparam logic [6:0] OP_ADD   = 7'h02;
  localparam logic [6:0] OP_SUB   = 7'h03;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LD_A   = 4'd1,
    S_WR_A   = 4'd2,
    S_WR_B   = 4'd3,
    S_EXEC   = 4'd4,
    S_ST_RD  = 4'd5,
    S_DM_WR  = 4'd6,
    S_VF_RD  = 4'd7,
    S_VF_CHK = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [6:0]          op_q;
  logic [ADDRW-1:0]    rs1_q;
  logic [ADDRW-1:0]    rs2_q;
  logic [ADDRW-1:0]    rd_q;
  logic [WORDSIZE-1:0] result_q;
  logic                err_q;

  logic                accept;
  logic                op_known;

  assign accept   = (state == S_IDLE) && start;
  assign op_known = (op_code == OP_NONE) || (op_code == OP_STORE) ||
                    (op_code == OP_ADD)  || (op_code == OP_SUB);

  // State register plus the instruction latch, result register and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q  <= op_code;
        rs1_q <= rs1;
        rs2_q <= rs2;
        rd_q  <= rd;
        err_q <= !op_known;
      end
      if (state == S_EXEC) begin
        result_q <= adder_sub_result;
      end
      if (state == S_ST_RD) begin
        result_q <= rf_data_a;
      end
`ifdef SEQ_READBACK_EN
      if ((state == S_VF_CHK) && (dm_data_output != result_q)) begin
        err_q <= 1'b1;
      end
`endif
    end
  end

  // Next-state decode and all datapath controls; every output idles at 0.
  always_comb begin
    state_next          = state;
    rf_write_en         = 1'b0;
    rf_write_addr       = '0;
    rf_write_data       = '0;
    rf_addr_a           = '0;
    rf_addr_b           = '0;
    dm_addr             = '0;
    dm_data_input       = '0;
    dm_write_enable     = 1'b0;
    dm_read             = 1'b0;
    adder_sub_factor_a  = '0;
    adder_sub_factor_b  = '0;
    adder_sub_operation = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          case (op_code)
            OP_ADD, OP_SUB: state_next = S_LD_A;
            OP_STORE:       state_next = S_ST_RD;
            default:        state_next = S_DONE;  // none or unknown
          endcase
        end
      end

      // Request mem[rs1]; the word arrives on dm_data_output next cycle.
      S_LD_A: begin
        dm_addr    = rs1_q;
        dm_read    = 1'b1;
        state_next = S_WR_A;
      end

      // Store mem[rs1] into rf[rs1] while requesting mem[rs2].
      S_WR_A: begin
        rf_write_en   = 1'b1;
        rf_write_addr = rs1_q;
        rf_write_data = dm_data_output;
        dm_addr       = rs2_q;
        dm_read       = 1'b1;
        state_next    = S_WR_B;
      end

      // Store mem[rs2] into rf[rs2]; with rs1==rs2 this rewrites the same value.
      S_WR_B: begin
        rf_write_en   = 1'b1;
        rf_write_addr = rs2_q;
        rf_write_data = dm_data_output;
        state_next    = S_EXEC;
      end

      // Feed both register operands to the ALU; result is captured at the edge.
      S_EXEC: begin
        rf_addr_a           = rs1_q;
        rf_addr_b           = rs2_q;
        adder_sub_factor_a  = rf_data_a;
        adder_sub_factor_b  = rf_data_b;
        adder_sub_operation = (op_q == OP_SUB);
        state_next          = S_DM_WR;
      end

      // Store path: rf[rs1] is captured into result at the edge.
      S_ST_RD: begin
        rf_addr_a  = rs1_q;
        state_next = S_DM_WR;
      end

      S_DM_WR: begin
        dm_addr         = rd_q;
        dm_data_input   = result_q;
        dm_write_enable = 1'b1;
`ifdef SEQ_READBACK_EN
        state_next      = S_VF_RD;
`else
        state_next      = S_DONE;
`endif
      end

`ifdef SEQ_READBACK_EN
      S_VF_RD: begin
        dm_addr    = rd_q;
        dm_read    = 1'b1;
        state_next = S_VF_CHK;
      end

      // Address held steady while the readback word is compared.
      S_VF_CHK: begin
        dm_addr    = rd_q;
        state_next = S_DONE;
      end
`endif

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign error     = (state == S_DONE) && err_q;
  assign result    = result_q;
  assign state_dbg = state;

endmodule
